// File: rtl/data_port_arbiter_if.sv
// One sram-like data port: request fields from the master, address/data
// acknowledgements and read data back from the slave.
//
// Handshake: req is the master's valid and is held with stable fields until
// addr_ok (the slave's ready) is seen high in the same cycle; that cycle
// transfers the address phase. data_ok is a one-cycle completion pulse,
// returned in the order the address phases were accepted, with rdata valid
// in that same cycle.
interface data_port_arbiter_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [3:0]  wstrb;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, addr, wstrb, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, addr, wstrb, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/data_port_arbiter.sv
// data_port_arbiter: shares one downstream sram-like data port between
// M0 (data-cache refill path) and M1 (uncached / store-buffer path).
// A small in-order grant-ID queue steers each downstream completion back to
// the master that issued it. No cycles are added on either phase.
//
// Build option: define ARB_RR_EN for round-robin tie breaking (last_grant
// register is built, M0_PRIO ignored); leave it undefined for fixed
// priority selected by M0_PRIO.
module data_port_arbiter #(
   parameter int OUTSTANDING = 2,
   parameter bit M0_PRIO     = 1'b1
) (
   input  logic                      clk,
   input  logic                      resetn,
   data_port_arbiter_if.slave        m0,
   data_port_arbiter_if.slave        m1,
   data_port_arbiter_if.master       out,
   output logic                      dbg_locked,
   output logic [$clog2((OUTSTANDING > 1) ? OUTSTANDING : 2):0] dbg_count
);

   localparam int PTR_W = $clog2((OUTSTANDING > 1) ? OUTSTANDING : 2);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTSTANDING);

   // Lock FSM: OPEN lets the grant follow the requests, LOCKED pins the
   // grant recorded when the downstream stalled an address phase.
   typedef enum logic {
      ST_OPEN   = 1'b0,
      ST_LOCKED = 1'b1
   } lock_state_t;

   lock_state_t state_q, state_d;
   logic        lock_gnt_q, lock_gnt_d;

   // Grant-ID queue: one bit per entry (0 = M0, 1 = M1)
   logic [OUTSTANDING-1:0] gid_q;
   logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]       count_q;

   // Held read data for whichever master is not being completed
   logic [31:0] m0_rdata_q, m1_rdata_q;

   logic any_req;
   logic tie_gnt;
   logic grant;
   logic full;
   logic push;
   logic pop;
   logic head_gnt;

`ifdef ARB_RR_EN
   logic last_grant_q;
`endif

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign any_req  = m0.req | m1.req;
   assign head_gnt = gid_q[rd_ptr_q];

   // A completion against an empty queue is a protocol error and is dropped.
   assign pop = out.data_ok & (count_q != '0);

   // A completion in the same cycle frees a slot, so a full queue still
   // admits a new address phase then (push and pop together).
   assign full = (count_q == CNT_FULL) & ~pop;

   // Tie-break choice when both masters request with no lock held
   always_comb begin
`ifdef ARB_RR_EN
      tie_gnt = ~last_grant_q;
`else
      tie_gnt = ~M0_PRIO;
`endif
   end

   // Grant selection: pinned while locked, otherwise the sole requester or the tie winner
   always_comb begin
      grant = 1'b0;
      if (state_q == ST_LOCKED) begin
         grant = lock_gnt_q;
      end else if (m0.req && !m1.req) begin
         grant = 1'b0;
      end else if (!m0.req && m1.req) begin
         grant = 1'b1;
      end else if (m0.req && m1.req) begin
         grant = tie_gnt;
      end
   end

   // Downstream request: pure mux of the granted master's fields
   assign out.req   = any_req & ~full;
   assign out.wr    = grant ? m1.wr    : m0.wr;
   assign out.size  = grant ? m1.size  : m0.size;
   assign out.addr  = grant ? m1.addr  : m0.addr;
   assign out.wstrb = grant ? m1.wstrb : m0.wstrb;
   assign out.wdata = grant ? m1.wdata : m0.wdata;

   assign push = out.req & out.addr_ok;

   assign m0.addr_ok = push & ~grant;
   assign m1.addr_ok = push &  grant;

   assign m0.data_ok = pop & ~head_gnt;
   assign m1.data_ok = pop &  head_gnt;

   assign m0.rdata = m0.data_ok ? out.rdata : m0_rdata_q;
   assign m1.rdata = m1.data_ok ? out.rdata : m1_rdata_q;

   assign dbg_locked = (state_q == ST_LOCKED);
   assign dbg_count  = count_q;

   // Lock FSM next state: lock on a stalled request, release on acceptance
   always_comb begin
      state_d    = state_q;
      lock_gnt_d = lock_gnt_q;
      case (state_q)
         ST_OPEN: begin
            if (out.req && !out.addr_ok) begin
               state_d    = ST_LOCKED;
               lock_gnt_d = grant;
            end
         end
         ST_LOCKED: begin
            if (out.addr_ok) begin
               state_d = ST_OPEN;
            end
         end
         default: begin
            state_d = ST_OPEN;
         end
      endcase
   end

   // Lock FSM state register and recorded grant
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= ST_OPEN;
         lock_gnt_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         lock_gnt_q <= lock_gnt_d;
      end
   end

   // Grant-ID queue: push grant at tail on acceptance, pop head on completion
   always_ff @(posedge clk) begin
      if (!resetn) begin
         gid_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            gid_q[wr_ptr_q] <= grant;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Capture completed read data so each master's rdata holds between completions
   always_ff @(posedge clk) begin
      if (!resetn) begin
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
      end else begin
         if (m0.data_ok) begin
            m0_rdata_q <= out.rdata;
         end
         if (m1.data_ok) begin
            m1_rdata_q <= out.rdata;
         end
      end
   end

`ifdef ARB_RR_EN
   // Round-robin history: remember who won the most recent accepted address phase
   always_ff @(posedge clk) begin
      if (!resetn) begin
         last_grant_q <= 1'b1;
      end else if (push) begin
         last_grant_q <= grant;
      end
   end
`endif

endmodule

// File: tb/tb_data_port_arbiter.sv
// Self-checking bench for data_port_arbiter (OUTSTANDING=2, M0_PRIO=1).
// Tie-break expectations follow ARB_RR_EN when it is defined.
module tb_data_port_arbiter;

   logic       clk;
   logic       resetn;
   logic       dbg_locked;
   logic [1:0] dbg_count;

   data_port_arbiter_if m0_if ();
   data_port_arbiter_if m1_if ();
   data_port_arbiter_if out_if ();

   data_port_arbiter #(
      .OUTSTANDING (2),
      .M0_PRIO     (1'b1)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .m0         (m0_if),
      .m1         (m1_if),
      .out        (out_if),
      .dbg_locked (dbg_locked),
      .dbg_count  (dbg_count)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   // entry = {expected master id, read data the downstream will return}
   logic [32:0] exp_q[$];
   logic [31:0] last_rd0;
   logic [31:0] last_rd1;
   int          n_cmp;
   int          n_err;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle();
      m0_if.req = 1'b0; m0_if.wr = 1'b0; m0_if.size = 2'd0; m0_if.addr = '0;
      m0_if.wstrb = '0; m0_if.wdata = '0;
      m1_if.req = 1'b0; m1_if.wr = 1'b0; m1_if.size = 2'd0; m1_if.addr = '0;
      m1_if.wstrb = '0; m1_if.wdata = '0;
      out_if.addr_ok = 1'b0; out_if.data_ok = 1'b0; out_if.rdata = '0;
   endtask

   task automatic set_m0(input logic req, input logic wr, input logic [31:0] addr,
                         input logic [3:0] wstrb, input logic [31:0] wdata);
      m0_if.req = req; m0_if.wr = wr; m0_if.size = 2'd2; m0_if.addr = addr;
      m0_if.wstrb = wstrb; m0_if.wdata = wdata;
   endtask

   task automatic set_m1(input logic req, input logic wr, input logic [31:0] addr,
                         input logic [3:0] wstrb, input logic [31:0] wdata);
      m1_if.req = req; m1_if.wr = wr; m1_if.size = 2'd2; m1_if.addr = addr;
      m1_if.wstrb = wstrb; m1_if.wdata = wdata;
   endtask

   task automatic apply_reset(input string tag);
      @(negedge clk);
      resetn = 1'b0;
      idle();
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      exp_q.delete();
      last_rd0 = '0;
      last_rd1 = '0;
      #1;
      check({tag, "_m0_aok"}, m0_if.addr_ok, 1'b0);
      check({tag, "_m0_dok"}, m0_if.data_ok, 1'b0);
      check({tag, "_m0_rdata"}, m0_if.rdata, 32'h0);
      check({tag, "_m1_aok"}, m1_if.addr_ok, 1'b0);
      check({tag, "_m1_dok"}, m1_if.data_ok, 1'b0);
      check({tag, "_m1_rdata"}, m1_if.rdata, 32'h0);
      check({tag, "_out_req"}, out_if.req, 1'b0);
      check({tag, "_count"}, dbg_count, 2'd0);
      check({tag, "_locked"}, dbg_locked, 1'b0);
   endtask

   // Called just after a negedge once requests/addr_ok are driven.
   // acc: expected accepted master this cycle (-1 none). cpl: downstream completes.
   task automatic run_cycle(input string tag, input int acc, input bit cpl,
                            input logic [31:0] new_data);
      logic [32:0] head;
      bit          do_cpl;
      head   = '0;
      do_cpl = cpl;
      if (do_cpl) begin
         check({tag, "_sb_nonempty"}, exp_q.size() != 0, 1'b1);
         if (exp_q.size() == 0) do_cpl = 1'b0;
      end
      if (do_cpl) begin
         head           = exp_q[0];
         out_if.data_ok = 1'b1;
         out_if.rdata   = head[31:0];
      end else begin
         out_if.data_ok = 1'b0;
         out_if.rdata   = $urandom;
      end
      #1;
      check({tag, "_m0_aok"}, m0_if.addr_ok, acc == 0);
      check({tag, "_m1_aok"}, m1_if.addr_ok, acc == 1);
      if (acc >= 0) check({tag, "_out_addr"}, out_if.addr, (acc == 0) ? m0_if.addr : m1_if.addr);
      if (do_cpl) begin
         check({tag, "_m0_dok"}, m0_if.data_ok, head[32] == 1'b0);
         check({tag, "_m1_dok"}, m1_if.data_ok, head[32] == 1'b1);
         if (head[32]) last_rd1 = head[31:0];
         else          last_rd0 = head[31:0];
         void'(exp_q.pop_front());
      end else begin
         check({tag, "_m0_dok"}, m0_if.data_ok, 1'b0);
         check({tag, "_m1_dok"}, m1_if.data_ok, 1'b0);
      end
      check({tag, "_m0_rdata"}, m0_if.rdata, last_rd0);
      check({tag, "_m1_rdata"}, m1_if.rdata, last_rd1);
      if (acc >= 0) exp_q.push_back({acc[0], new_data});
   endtask

   task automatic drain(input string tag);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 8) begin
         @(negedge clk);
         set_m0(1'b0, 1'b0, '0, '0, '0);
         set_m1(1'b0, 1'b0, '0, '0, '0);
         out_if.addr_ok = 1'b0;
         run_cycle($sformatf("%s_drain%0d", tag, k), -1, 1'b1, '0);
         k++;
      end
      check({tag, "_drained"}, exp_q.size(), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int g;
      n_cmp    = 0;
      n_err    = 0;
      last_rd0 = '0;
      last_rd1 = '0;
      resetn   = 1'b0;
      idle();

      apply_reset("rst0");

      // Single M0 read, completion three cycles later
      @(negedge clk);
      set_m0(1'b1, 1'b0, 32'h0000_1000, 4'h0, '0);
      out_if.addr_ok = 1'b1;
      run_cycle("s1_c0", 0, 1'b0, 32'hDEAD_BEEF);
      check("s1_out_req", out_if.req, 1'b1);
      check("s1_out_wr", out_if.wr, 1'b0);
      check("s1_out_size", out_if.size, 2'd2);
      for (int c = 1; c < 3; c++) begin
         @(negedge clk);
         set_m0(1'b0, 1'b0, '0, '0, '0);
         out_if.addr_ok = 1'b0;
         run_cycle($sformatf("s1_c%0d", c), -1, 1'b0, '0);
         check($sformatf("s1_c%0d_count", c), dbg_count, 2'd1);
      end
      @(negedge clk);
      run_cycle("s1_c3", -1, 1'b1, '0);
      check("s1_c3_m0_rdata_val", m0_if.rdata, 32'hDEAD_BEEF);
      @(negedge clk);
      run_cycle("s1_c4", -1, 1'b0, '0);
      check("s1_c4_count", dbg_count, 2'd0);

      // Tie after reset: M0 first, then M1
      apply_reset("rst1");
      @(negedge clk);
      set_m0(1'b1, 1'b0, 32'h0000_1200, 4'h0, '0);
      set_m1(1'b1, 1'b1, 32'h0000_2200, 4'hF, 32'h1111_2222);
      out_if.addr_ok = 1'b1;
      run_cycle("s2_c0", 0, 1'b0, $urandom);
      @(negedge clk);
      set_m0(1'b0, 1'b0, '0, '0, '0);
      run_cycle("s2_c1", 1, 1'b0, $urandom);
      drain("s2");

      // Four back-to-back ties with completions keeping the queue from filling
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         set_m0(1'b1, 1'b0, 32'h0000_3000 + 32'(i * 4), 4'h0, '0);
         set_m1(1'b1, 1'b1, 32'h0000_4000 + 32'(i * 4), 4'hF, $urandom);
         out_if.addr_ok = 1'b1;
`ifdef ARB_RR_EN
         g = i % 2;
`else
         g = 0;
`endif
         run_cycle($sformatf("tie%0d", i), g, exp_q.size() != 0, $urandom);
      end
      drain("tie");

      // Lock: M1 write stalled two cycles, M0 arrives during the stall
      @(negedge clk);
      set_m0(1'b0, 1'b0, '0, '0, '0);
      set_m1(1'b1, 1'b1, 32'h0000_2004, 4'hF, 32'hCAFE_F00D);
      out_if.addr_ok = 1'b0;
      run_cycle("s3_c0", -1, 1'b0, '0);
      check("s3_c0_out_req", out_if.req, 1'b1);
      check("s3_c0_out_addr", out_if.addr, 32'h0000_2004);
      check("s3_c0_out_wr", out_if.wr, 1'b1);
      check("s3_c0_out_wstrb", out_if.wstrb, 4'hF);
      check("s3_c0_out_wdata", out_if.wdata, 32'hCAFE_F00D);
      @(negedge clk);
      set_m0(1'b1, 1'b0, 32'h0000_1100, 4'h0, '0);
      run_cycle("s3_c1", -1, 1'b0, '0);
      check("s3_c1_out_addr", out_if.addr, 32'h0000_2004);
      check("s3_c1_locked", dbg_locked, 1'b1);
      @(negedge clk);
      out_if.addr_ok = 1'b1;
      run_cycle("s3_c2", 1, 1'b0, $urandom);
      @(negedge clk);
      set_m1(1'b0, 1'b0, '0, '0, '0);
      run_cycle("s3_c3", 0, 1'b0, $urandom);
      check("s3_c3_locked", dbg_locked, 1'b0);
      drain("s3");

      // Full queue: third M0 read blocked, readmitted on the first completion
      @(negedge clk);
      set_m0(1'b1, 1'b0, 32'h0000_5000, 4'h0, '0);
      out_if.addr_ok = 1'b1;
      run_cycle("s4_c0", 0, 1'b0, $urandom);
      @(negedge clk);
      set_m0(1'b1, 1'b0, 32'h0000_5004, 4'h0, '0);
      run_cycle("s4_c1", 0, 1'b0, $urandom);
      @(negedge clk);
      set_m0(1'b1, 1'b0, 32'h0000_5008, 4'h0, '0);
      run_cycle("s4_c2", -1, 1'b0, '0);
      check("s4_c2_out_req", out_if.req, 1'b0);
      check("s4_c2_count", dbg_count, 2'd2);
      @(negedge clk);
      run_cycle("s4_c3", 0, 1'b1, $urandom);
      check("s4_c3_out_req", out_if.req, 1'b1);
      @(negedge clk);
      set_m0(1'b0, 1'b0, '0, '0, '0);
      out_if.addr_ok = 1'b0;
      run_cycle("s4_c4", -1, 1'b0, '0);
      check("s4_c4_count", dbg_count, 2'd2);
      drain("s4");

      // Interleaved M0 read / M1 write, completions routed in order
      @(negedge clk);
      set_m0(1'b1, 1'b0, 32'h0000_6000, 4'h0, '0);
      out_if.addr_ok = 1'b1;
      run_cycle("s5_c0", 0, 1'b0, $urandom);
      @(negedge clk);
      set_m0(1'b0, 1'b0, '0, '0, '0);
      set_m1(1'b1, 1'b1, 32'h0000_7000, 4'h3, 32'h0000_ABCD);
      run_cycle("s5_c1", 1, 1'b0, $urandom);
      @(negedge clk);
      set_m1(1'b0, 1'b0, '0, '0, '0);
      out_if.addr_ok = 1'b0;
      run_cycle("s5_c2", -1, 1'b1, '0);
      @(negedge clk);
      run_cycle("s5_c3", -1, 1'b1, '0);

      // Two more in flight, then reset discards them
      @(negedge clk);
      set_m1(1'b1, 1'b0, 32'h0000_7100, 4'h0, '0);
      out_if.addr_ok = 1'b1;
      run_cycle("s5_c4", 1, 1'b0, $urandom);
      @(negedge clk);
      set_m1(1'b0, 1'b0, '0, '0, '0);
      set_m0(1'b1, 1'b0, 32'h0000_6100, 4'h0, '0);
      run_cycle("s5_c5", 0, 1'b0, $urandom);
      apply_reset("rst2");

      // Completion with an empty queue is ignored
      @(negedge clk);
      out_if.data_ok = 1'b1;
      out_if.rdata   = 32'h55AA_55AA;
      #1;
      check("err_m0_dok", m0_if.data_ok, 1'b0);
      check("err_m1_dok", m1_if.data_ok, 1'b0);
      check("err_m0_rdata", m0_if.rdata, 32'h0);
      check("err_m1_rdata", m1_if.rdata, 32'h0);
      @(negedge clk);
      out_if.data_ok = 1'b0;
      #1;
      check("err_count", dbg_count, 2'd0);

      // ---------------- final report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
